// File: rtl/soc_bram_arb_if.sv
// Request/response channel between a BRAM master and its slave.
// The arbiter uses two slave views (m0, m1) and one master view (s).
interface soc_bram_arb_if #(
    parameter int addr_width = 8
);
    logic [addr_width-1:0] addr;
    logic [31:0]           dwrite;
    logic                  rw;
    logic                  valid;
    logic [31:0]           dread;
    logic                  done;

    modport master (output addr, dwrite, rw, valid, input  dread, done);
    modport slave  (input  addr, dwrite, rw, valid, output dread, done);
endinterface

// File: rtl/soc_bram_arb.sv
// Two-master arbiter/sequencer in front of the byte-addressable BRAM controller.
// Define SOC_BRAM_ARB_RR_EN for round-robin arbitration; otherwise m0 has fixed priority.
module soc_bram_arb #(
    parameter int addr_width = 8
) (
    input  logic                clk,
    input  logic                rstn,
    soc_bram_arb_if.slave       m0,
    soc_bram_arb_if.slave       m1,
    soc_bram_arb_if.master      s,
    output logic [1:0]          grant,
    output logic                busy
);

    typedef enum logic [1:0] {DRAIN, IDLE, ISSUE, WAIT} state_t;

    state_t     state;
    logic [1:0] drain_cnt;
    logic       pick_m1;
    logic       done_ok;

`ifdef SOC_BRAM_ARB_RR_EN
    logic rr_m1;
    assign pick_m1 = m1.valid & (~m0.valid | rr_m1);
`else
    assign pick_m1 = ~m0.valid;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= DRAIN;
            drain_cnt <= 2'd3;
            grant     <= '0;
            s.valid   <= 1'b0;
            s.addr    <= '0;
            s.dwrite  <= '0;
            s.rw      <= 1'b0;
`ifdef SOC_BRAM_ARB_RR_EN
            rr_m1     <= 1'b0;
`endif
        end else begin
            s.valid <= 1'b0;
            case (state)
                // The controller has no reset: swallow any done still in flight.
                DRAIN: begin
                    if (drain_cnt == '0) state <= IDLE;
                    else                 drain_cnt <= drain_cnt - 2'd1;
                end
                IDLE: begin
                    if (m0.valid | m1.valid) begin
                        state   <= ISSUE;
                        s.valid <= 1'b1;
                        if (pick_m1) begin
                            grant    <= 2'b10;
                            s.addr   <= m1.addr;
                            s.dwrite <= m1.dwrite;
                            s.rw     <= m1.rw;
                        end else begin
                            grant    <= 2'b01;
                            s.addr   <= m0.addr;
                            s.dwrite <= m0.dwrite;
                            s.rw     <= m0.rw;
                        end
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (s.done) begin
                        state <= IDLE;
                        grant <= '0;
`ifdef SOC_BRAM_ARB_RR_EN
                        rr_m1 <= grant[0];
`endif
                    end
                end
                default: state <= DRAIN;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign done_ok  = (state == WAIT) & s.done;
    assign m0.done  = done_ok & grant[0];
    assign m1.done  = done_ok & grant[1];
    assign m0.dread = s.dread;
    assign m1.dread = s.dread;

endmodule
